// File: rtl/decoder_scan_pkg.sv
// Shared types, enable encodings and the select-advance helper for decoder_scan_ctrl.
package decoder_scan_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    // {G, G2A, G2B}
    localparam logic [2:0] EN_ON  = 3'b100;
    localparam logic [2:0] EN_OFF = 3'b011;

    // Nearest unmasked position in the scan direction; holds if every other position is masked.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur,
                                                  input logic             dir,
                                                  input logic [7:0]       mask);
        logic [SEL_W-1:0] cand;
        logic             found;
        next_sel = cur;
        found    = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cand = dir ? cur - SEL_W'(i) : cur + SEL_W'(i);
            if (!found && !mask[cand]) begin
                next_sel = cand;
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_prescaler.sv
// Scan-period prescaler: counts 0..DIV_MAX while running, registered tick after terminal count.
module scan_prescaler #(
    parameter int unsigned DIV_MAX = 99999,
    parameter int unsigned DIV_W   = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tc,
    output logic tick
);

    logic [DIV_W-1:0] cnt;

    assign tc = run && (cnt == DIV_W'(DIV_MAX));

    // Tick still fires when a clear coincides with the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= tc;
            if (clear)
                cnt <= '0;
            else if (run)
                cnt <= (cnt == DIV_W'(DIV_MAX)) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving a 74LS138 with break-before-make gaps around each select change.
// Optional feature: define SCAN_SKIP_EN to add the skip_mask input.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DIV_MAX = 99999,
    parameter int unsigned DIV_W   = 17,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       blank,
`ifdef SCAN_SKIP_EN
    input  logic [7:0] skip_mask,
`endif
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       G,
    output logic       G2A,
    output logic       G2B,
    output logic       tick,
    output logic [2:0] sel
);

    localparam int GCNT_W = $clog2(GAP_CYC);

    state_t            state;
    logic [GCNT_W-1:0] gcnt;
    logic [2:0]        en_bits;
    logic [7:0]        mask;
    logic              blank_eff;
    logic              tc;
    logic              run;
    logic              clear;

`ifdef SCAN_SKIP_EN
    assign mask = skip_mask;
`else
    assign mask = 8'h00;
`endif

    // A fully masked ring has nothing to show, so it behaves as blank.
    assign blank_eff = blank || (&mask);
    assign run       = (state != IDLE);
    assign clear     = load || !en || (state == IDLE);

    scan_prescaler #(.DIV_MAX(DIV_MAX), .DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .clear(clear),
        .tc   (tc),
        .tick (tick)
    );

    assign {G, G2A, G2B} = en_bits;
    assign {C, B, A}     = sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= '0;
            gcnt    <= '0;
            en_bits <= EN_OFF;
        end else begin
            // NOTE: enables default off here and are switched on only where the next state is an unblanked RUN.
            en_bits <= EN_OFF;
            if (load) begin
                sel <= load_val;
                if (en) begin
                    state <= GAP;
                    gcnt  <= GCNT_W'(GAP_CYC - 2);
                end else begin
                    state <= IDLE;
                end
            end else if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= RUN;
                        if (!blank_eff) en_bits <= EN_ON;
                    end
                    RUN: begin
                        if (tc) begin
                            state <= GAP;
                            gcnt  <= GCNT_W'(GAP_CYC - 1);
                        end else if (!blank_eff) begin
                            en_bits <= EN_ON;
                        end
                    end
                    GAP: begin
                        if (gcnt == GCNT_W'(GAP_CYC - 1))
                            sel <= next_sel(sel, dir, mask);
                        if (gcnt == '0) begin
                            state <= RUN;
                            if (!blank_eff) en_bits <= EN_ON;
                        end else begin
                            gcnt <= gcnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: directed phases plus random stimulus against a behavioural model.
module tb_decoder_scan_ctrl;

    localparam int DIV_MAX = 3;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n, en, dir, load, blank;
    logic [2:0] load_val;
`ifdef SCAN_SKIP_EN
    logic [7:0] mask_drv;
`endif
    logic       A, B, C, G, G2A, G2B, tick;
    logic [2:0] sel;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DIV_MAX(DIV_MAX), .DIV_W(2), .GAP_CYC(GAP_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .dir     (dir),
        .load    (load),
        .load_val(load_val),
        .blank   (blank),
`ifdef SCAN_SKIP_EN
        .skip_mask(mask_drv),
`endif
        .A       (A),
        .B       (B),
        .C       (C),
        .G       (G),
        .G2A     (G2A),
        .G2B     (G2B),
        .tick    (tick),
        .sel     (sel)
    );

    typedef struct packed {
        logic [2:0] s;
        logic [2:0] enb;
        logic       tk;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: scanning flag, scan-period position, remaining gap cycles, select.
    bit         m_on;
    int         m_cnt;
    int         m_gap;
    int         m_sel;
    bit         m_tick;
    logic [2:0] m_enb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int advance(input int s, input bit d, input logic [7:0] m);
        int c;
        for (int k = 1; k < 8; k++) begin
            c = d ? (s + 8 - k) % 8 : (s + k) % 8;
            if (!m[c]) return c;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_on = 0; m_cnt = 0; m_gap = 0; m_sel = 0; m_tick = 0; m_enb = 3'b011;
    endtask

    task automatic model_step(input bit e, input bit d, input bit ld, input logic [2:0] lv,
                              input bit bl, input logic [7:0] m);
        m_tick = m_on && (m_cnt == DIV_MAX);
        if (ld) begin
            m_sel = int'(lv);
            m_cnt = 0;
            m_on  = e;
            m_gap = e ? GAP_CYC - 1 : 0;
        end else if (!e) begin
            m_on = 0; m_cnt = 0; m_gap = 0;
        end else if (!m_on) begin
            m_on = 1; m_cnt = 0; m_gap = 0;
        end else begin
            if (m_gap == GAP_CYC) m_sel = advance(m_sel, d, m);
            if (m_gap > 0)               m_gap = m_gap - 1;
            else if (m_cnt == DIV_MAX)   m_gap = GAP_CYC;
            m_cnt = (m_cnt == DIV_MAX) ? 0 : m_cnt + 1;
        end
        m_enb = (m_on && m_gap == 0 && !bl && !(&m)) ? 3'b100 : 3'b011;
    endtask

    task automatic push_exp();
        exp_t e;
        e.s   = 3'(m_sel);
        e.enb = m_enb;
        e.tk  = m_tick;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs, predict the post-edge outputs, wait for the next falling edge.
    task automatic drive(input bit e, input bit d, input bit ld, input logic [2:0] lv,
                         input bit bl, input logic [7:0] m);
        logic [7:0] em;
`ifdef SCAN_SKIP_EN
        em       = m;
        mask_drv = m;
`else
        em = 8'h00;
`endif
        en = e; dir = d; load = ld; load_val = lv; blank = bl;
        model_step(e, d, ld, lv, bl, em);
        push_exp();
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        rst_n = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest prediction.
    initial begin
        exp_t       e;
        logic [2:0] prev_sel = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {sel, C, B, A, G, G2A, G2B, tick}, {e.s, e.s, e.enb, e.tk});
                if (sel != prev_sel)
                    check("sel_change_enables_off", {G, G2A, G2B}, 3'b011);
                prev_sel = sel;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rm;
        bit         hit;
        rst_n = 1'b0; en = 0; dir = 0; load = 0; load_val = 0; blank = 0;
`ifdef SCAN_SKIP_EN
        mask_drv = 8'h00;
`endif
        repeat (3) reset_cycle();
        rst_n = 1'b1;

        repeat (10) drive(0, 0, 0, 3'd0, 0, 8'h00);
        repeat (40) drive(1, 0, 0, 3'd0, 0, 8'h00);

        drive(1, 1, 1, 3'd0, 0, 8'h00);
        repeat (12) drive(1, 1, 0, 3'd0, 0, 8'h00);

        repeat (3) drive(1, 0, 0, 3'd0, 0, 8'h00);
        drive(1, 0, 1, 3'd5, 0, 8'h00);
        repeat (8) drive(1, 0, 0, 3'd0, 0, 8'h00);

        repeat (8) drive(1, 0, 0, 3'd0, 1, 8'h00);
        repeat (2) drive(1, 0, 0, 3'd0, 0, 8'h00);

        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive(1, 0, 0, 3'd0, 0, 8'h00);
            hit = (m_gap > 0);
        end
        check("reached_gap_for_en_drop", 32'(hit), 32'd1);
        repeat (3) drive(0, 0, 0, 3'd0, 0, 8'h00);

`ifdef SCAN_SKIP_EN
        drive(1, 0, 1, 3'd0, 0, 8'b0000_0110);
        repeat (12) drive(1, 0, 0, 3'd0, 0, 8'b0000_0110);
        repeat (10) drive(1, 0, 0, 3'd0, 0, 8'hFF);
`endif

        for (int i = 0; i < 1500; i++) begin
            rm = 8'h00;
`ifdef SCAN_SKIP_EN
            case ($urandom % 4)
                0:       rm = 8'($urandom);
                1:       rm = ($urandom % 8 == 0) ? 8'hFF : 8'h00;
                default: rm = 8'h00;
            endcase
`endif
            drive(($urandom % 16) != 0, 1'($urandom), ($urandom % 20) == 0,
                  3'($urandom), ($urandom % 8) == 0, rm);
        end

        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive(1, 0, 0, 3'd0, 0, 8'h00);
            hit = (m_gap > 0);
        end
        check("reached_gap_for_reset", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset", {sel, G, G2A, G2B, tick}, {3'd0, 3'b011, 1'b0});
        model_reset();
        push_exp();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) drive(1, 0, 0, 3'd0, 0, 8'h00);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
